pixel_collector: RTL and testbench

Gathers per-pixel results from the NUM_ENGINES parallel pixel engines and streams them out one pixel per beat in raster order, with valid/ready flow control. It is the return path of the coordinate distributor. When a full batch has been captured, it pulses fin_flag, which advances the distributor's coordinates and restarts the engines while the current batch drains. The x/y it attaches to each beat must match the coordinates the distributor issued for that batch.

---
 rtl/pixel_pkg.sv | 15 +
 rtl/raster_counter.sv | 50 +++++
 rtl/pixel_collector.sv | 108 ++++++++++
 tb/tb_pixel_collector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared defaults and types for the pixel distributor/collector pair.
package pixel_pkg;

    localparam int unsigned PIXEL_DATA_WIDTH = 10;
    localparam int unsigned SCREEN_WIDTH     = 640;
    localparam int unsigned SCREEN_HEIGHT    = 480;
    localparam int unsigned NUM_ENGINES      = 8;
    localparam int unsigned RESULT_WIDTH     = 8;

    typedef enum logic {
        WAIT   = 1'b0,
        STREAM = 1'b1
    } collector_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter with compare-and-wrap at line and frame ends.
module raster_counter #(
    parameter int unsigned WIDTH         = pixel_pkg::PIXEL_DATA_WIDTH,
    parameter int unsigned SCREEN_WIDTH  = pixel_pkg::SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = pixel_pkg::SCREEN_HEIGHT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             at_sof,
    output logic             at_eof
);

    localparam logic [WIDTH-1:0] X_LAST = WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(SCREEN_HEIGHT - 1);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + WIDTH'(1);
            end else begin
                x_d = x_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign at_sof = (x_q == '0) && (y_q == '0);
    assign at_eof = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/pixel_collector.sv
// Captures one result per engine when all are done, then streams them out
// in raster order with valid/ready, pulsing fin_flag on each capture.
module pixel_collector #(
    parameter int unsigned PIXEL_DATA_WIDTH = pixel_pkg::PIXEL_DATA_WIDTH,
    parameter int unsigned SCREEN_WIDTH     = pixel_pkg::SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT    = pixel_pkg::SCREEN_HEIGHT,
    parameter int unsigned NUM_ENGINES      = pixel_pkg::NUM_ENGINES,
    parameter int unsigned RESULT_WIDTH     = pixel_pkg::RESULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_ENGINES-1:0]      eng_done,
    input  logic [RESULT_WIDTH-1:0]     eng_result [NUM_ENGINES-1:0],
    output logic                        fin_flag,
    output logic [RESULT_WIDTH-1:0]     out_data,
    output logic [PIXEL_DATA_WIDTH-1:0] out_x,
    output logic [PIXEL_DATA_WIDTH-1:0] out_y,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        out_valid,
    input  logic                        out_ready
);

    import pixel_pkg::*;

    localparam int unsigned      IDX_W    = $clog2(NUM_ENGINES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENGINES - 1);

    collector_state_t        state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [RESULT_WIDTH-1:0] buffer_q [NUM_ENGINES-1:0];
    logic [RESULT_WIDTH-1:0] buffer_d [NUM_ENGINES-1:0];
    logic [RESULT_WIDTH-1:0] data_q, data_d;
    logic                    fin_q, fin_d;
    logic                    at_sof, at_eof;
    logic                    advance;

    // out_data is preloaded with the next beat so it leaves a flop directly.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buffer_d = buffer_q;
        data_d   = data_q;
        fin_d    = 1'b0;
        case (state_q)
            WAIT: begin
                if (&eng_done) begin
                    buffer_d = eng_result;
                    idx_d    = '0;
                    data_d   = eng_result[0];
                    fin_d    = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = WAIT;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = buffer_q[idx_q + IDX_W'(1)];
                    end
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT;
            idx_q    <= '0;
            buffer_q <= '{default: '0};
            data_q   <= '0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buffer_q <= buffer_d;
            data_q   <= data_d;
            fin_q    <= fin_d;
        end
    end

    assign advance = (state_q == STREAM) && out_ready;

    raster_counter #(
        .WIDTH        (PIXEL_DATA_WIDTH),
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .x     (out_x),
        .y     (out_y),
        .at_sof(at_sof),
        .at_eof(at_eof)
    );

    assign out_valid = (state_q == STREAM);
    assign out_data  = data_q;
    assign fin_flag  = fin_q;
    assign out_sop   = out_valid && at_sof;
    assign out_eop   = out_valid && at_eof;

endmodule

// File: tb/tb_pixel_collector.sv
// Directed bench for pixel_collector: default screen, a 12-wide screen and a 4x2 screen driven in parallel.
module tb_pixel_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] done;
    logic [7:0] res [7:0];
    logic       ready;

    logic       a_fin, a_sop, a_eop, a_valid;
    logic [7:0] a_data;
    logic [9:0] a_x, a_y;
    logic       b_fin, b_sop, b_eop, b_valid;
    logic [7:0] b_data;
    logic [9:0] b_x, b_y;
    logic       c_fin, c_sop, c_eop, c_valid;
    logic [7:0] c_data;
    logic [9:0] c_x, c_y;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pixel_collector dut_a (
        .clk(clk), .reset(reset), .eng_done(done), .eng_result(res),
        .fin_flag(a_fin), .out_data(a_data), .out_x(a_x), .out_y(a_y),
        .out_sop(a_sop), .out_eop(a_eop), .out_valid(a_valid), .out_ready(ready)
    );

    pixel_collector #(.SCREEN_WIDTH(12)) dut_b (
        .clk(clk), .reset(reset), .eng_done(done), .eng_result(res),
        .fin_flag(b_fin), .out_data(b_data), .out_x(b_x), .out_y(b_y),
        .out_sop(b_sop), .out_eop(b_eop), .out_valid(b_valid), .out_ready(ready)
    );

    pixel_collector #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2)) dut_c (
        .clk(clk), .reset(reset), .eng_done(done), .eng_result(res),
        .fin_flag(c_fin), .out_data(c_data), .out_x(c_x), .out_y(c_y),
        .out_sop(c_sop), .out_eop(c_eop), .out_valid(c_valid), .out_ready(ready)
    );

    typedef struct {
        logic [7:0] done;
        logic       ready;
        logic       valid;
        logic       fin;
        logic [7:0] data;
        logic [9:0] ax;
        logic       sop;
        logic [9:0] cx;
        logic [9:0] cy;
        logic       ceop;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_results(input int base);
        for (int i = 0; i < 8; i++) res[i] = 8'(base + i);
    endtask

    initial begin
        reset = 1'b1;
        done  = 8'h00;
        ready = 1'b1;
        set_results(0);

        // batch 1 on all three: results 10..17, stall 3 cycles on beat 3
        vecs[0]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'd10, 10'd0, 1'b1, 10'd0, 10'd0, 1'b0};
        vecs[1]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd11, 10'd1, 1'b0, 10'd1, 10'd0, 1'b0};
        vecs[2]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd12, 10'd2, 1'b0, 10'd2, 10'd0, 1'b0};
        vecs[3]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd13, 10'd3, 1'b0, 10'd3, 10'd0, 1'b0};
        vecs[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'd13, 10'd3, 1'b0, 10'd3, 10'd0, 1'b0};
        vecs[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'd13, 10'd3, 1'b0, 10'd3, 10'd0, 1'b0};
        vecs[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'd13, 10'd3, 1'b0, 10'd3, 10'd0, 1'b0};
        vecs[7]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd14, 10'd4, 1'b0, 10'd0, 10'd1, 1'b0};
        vecs[8]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd15, 10'd5, 1'b0, 10'd1, 10'd1, 1'b0};
        vecs[9]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd16, 10'd6, 1'b0, 10'd2, 10'd1, 1'b0};
        vecs[10] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd17, 10'd7, 1'b0, 10'd3, 10'd1, 1'b1};
        vecs[11] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'd0,  10'd0, 1'b0, 10'd0, 10'd0, 1'b0};
        vecs[12] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'd0,  10'd0, 1'b0, 10'd0, 10'd0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_fin",   32'(a_fin),   32'd0);
        chk("rst_data",  32'(a_data),  32'd0);
        chk("rst_x",     32'(a_x),     32'd0);
        chk("rst_y",     32'(a_y),     32'd0);
        chk("rst_sop",   32'(a_sop),   32'd0);
        chk("rst_eop",   32'(a_eop),   32'd0);
        reset = 1'b0;

        set_results(10);
        for (int i = 0; i < 13; i++) begin
            done  = vecs[i].done;
            ready = vecs[i].ready;
            step();
            chk($sformatf("v%0d_valid", i), 32'(a_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_fin", i),   32'(a_fin),   32'(vecs[i].fin));
            chk($sformatf("v%0d_sop", i),   32'(a_sop),   32'(vecs[i].sop));
            chk($sformatf("v%0d_eop", i),   32'(a_eop),   32'd0);
            chk($sformatf("v%0d_ceop", i),  32'(c_eop),   32'(vecs[i].ceop));
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_data", i), 32'(a_data), 32'(vecs[i].data));
                chk($sformatf("v%0d_ax", i),   32'(a_x),    32'(vecs[i].ax));
                chk($sformatf("v%0d_ay", i),   32'(a_y),    32'd0);
                chk($sformatf("v%0d_cx", i),   32'(c_x),    32'(vecs[i].cx));
                chk($sformatf("v%0d_cy", i),   32'(c_y),    32'(vecs[i].cy));
            end
        end

        // batch 2: line wrap on the 12-wide screen, frame restart on the 4x2 screen
        set_results(20);
        done  = 8'hFF;
        ready = 1'b1;
        step();
        chk("b2_fin", 32'(a_fin), 32'd1);
        done = 8'h00;
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("b2_%0d_valid", b), 32'(a_valid), 32'd1);
            chk($sformatf("b2_%0d_data", b),  32'(a_data),  32'(20 + b));
            chk($sformatf("b2_%0d_ax", b),    32'(a_x),     32'(8 + b));
            chk($sformatf("b2_%0d_bx", b),    32'(b_x),     (b < 4) ? 32'(8 + b) : 32'(b - 4));
            chk($sformatf("b2_%0d_by", b),    32'(b_y),     (b < 4) ? 32'd0 : 32'd1);
            chk($sformatf("b2_%0d_csop", b),  32'(c_sop),   (b == 0) ? 32'd1 : 32'd0);
            if (b == 0) begin
                chk("b2_0_cx", 32'(c_x), 32'd0);
                chk("b2_0_cy", 32'(c_y), 32'd0);
            end
            step();
        end
        chk("b2_end_valid", 32'(a_valid), 32'd0);

        // partial done must never capture
        set_results(30);
        done = 8'h7F;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("part_%0d_valid", k), 32'(a_valid), 32'd0);
            chk($sformatf("part_%0d_fin", k),   32'(a_fin),   32'd0);
        end
        done = 8'hFF;
        step();
        chk("full_fin",   32'(a_fin),   32'd1);
        chk("full_valid", 32'(a_valid), 32'd1);
        chk("full_data",  32'(a_data),  32'd30);
        chk("full_ax",    32'(a_x),     32'd16);
        done = 8'h00;
        step();
        chk("fin_single", 32'(a_fin),  32'd0);
        chk("b3_data1",   32'(a_data), 32'd31);
        repeat (3) step();
        chk("b3_data4",   32'(a_data), 32'd34);
        chk("b3_ax4",     32'(a_x),    32'd20);

        // asynchronous reset between edges at beat 4
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(a_valid), 32'd0);
        chk("arst_fin",   32'(a_fin),   32'd0);
        chk("arst_x",     32'(a_x),     32'd0);
        chk("arst_y",     32'(a_y),     32'd0);
        chk("arst_bx",    32'(b_x),     32'd0);
        chk("arst_cy",    32'(c_y),     32'd0);
        @(negedge clk);
        reset = 1'b0;

        set_results(40);
        done = 8'hFF;
        step();
        chk("post_fin",  32'(a_fin),  32'd1);
        chk("post_sop",  32'(a_sop),  32'd1);
        chk("post_data", 32'(a_data), 32'd40);
        chk("post_x",    32'(a_x),    32'd0);
        chk("post_y",    32'(a_y),    32'd0);
        done = 8'h00;
        step();
        chk("post_data1", 32'(a_data), 32'd41);
        chk("post_x1",    32'(a_x),    32'd1);
        chk("post_sop1",  32'(a_sop),  32'd0);
        repeat (8) step();
        chk("post_idle_valid", 32'(a_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
